// File: rtl/neuron_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : neuron_layer_sequencer
// Description : Buffers INPUT_COUNT unsigned input words, then evaluates
//               NEURON_COUNT threshold neurons one after another on a single
//               multiply-accumulate path fed from an external weight memory,
//               and presents the activation vector with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_layer_sequencer #(
   parameter int          INPUT_COUNT  = 4,
   parameter int          NEURON_COUNT = 4,
   parameter logic [31:0] BIAS         = 32'd0,
   parameter logic [31:0] THRESHOLD    = 32'd0,
   // Derived widths; not intended to be overridden
   parameter int          AW = (NEURON_COUNT * INPUT_COUNT > 1) ?
                               $clog2(NEURON_COUNT * INPUT_COUNT) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    x_valid,
   output logic                    x_ready,
   input  logic [31:0]             x_data,
   output logic                    w_rd_en,
   output logic [AW-1:0]           w_addr,
   input  logic [31:0]             w_data,
   output logic                    y_valid,
   input  logic                    y_ready,
   output logic [NEURON_COUNT-1:0] y_data
);

   // idx counts load slots in LOAD and issue/finish steps (0..INPUT_COUNT) in MAC
   localparam int IW = $clog2(INPUT_COUNT + 1);
   localparam int NW = (NEURON_COUNT > 1) ? $clog2(NEURON_COUNT) : 1;

   localparam logic [IW-1:0] LAST_IN = IW'(INPUT_COUNT - 1);
   localparam logic [IW-1:0] FINISH  = IW'(INPUT_COUNT);
   localparam logic [NW-1:0] LAST_N  = NW'(NEURON_COUNT - 1);

   localparam logic [1:0] S_LOAD = 2'd0;
   localparam logic [1:0] S_MAC  = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;

   logic [1:0]    state;
   logic [IW-1:0] idx;
   logic [NW-1:0] n;
   logic [31:0]   acc;

   // Buffer is sized to the full index range so any idx value is a legal index
   logic [31:0]   x_buf [0:(1 << IW) - 1];

   logic          issue;
   logic [31:0]   product;
   logic [31:0]   sum;

   // Weight read issue, product of the previous issue's operands and running sum
   always_comb begin
      issue   = (state == S_MAC) && (idx != FINISH);
      product = x_buf[idx - IW'(1)] * w_data;
      sum     = acc + product;
      w_rd_en = issue;
      w_addr  = issue ? (AW'(n) * AW'(INPUT_COUNT) + AW'(idx)) : '0;
      x_ready = (state == S_LOAD);
      y_valid = (state == S_OUT);
   end

   // Input buffer capture; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (state == S_LOAD && x_valid) begin
         x_buf[idx] <= x_data;
      end
   end

   // Sequencer FSM, counters, accumulator and result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_LOAD;
         idx    <= '0;
         n      <= '0;
         acc    <= BIAS;
         y_data <= '0;
      end else begin
         case (state)
            S_LOAD: begin
               if (x_valid) begin
                  if (idx == LAST_IN) begin
                     state <= S_MAC;
                     idx   <= '0;
                     n     <= '0;
                     acc   <= BIAS;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end
            end
            S_MAC: begin
               if (idx == FINISH) begin
                  // Last product folds straight into the compare; acc restarts
                  y_data[n] <= (sum > THRESHOLD);
                  acc       <= BIAS;
                  idx       <= '0;
                  if (n == LAST_N) begin
                     state <= S_OUT;
                     n     <= '0;
                  end else begin
                     n <= n + NW'(1);
                  end
               end else begin
                  // idx 0 has no read outstanding yet
                  if (idx != '0) begin
                     acc <= sum;
                  end
                  idx <= idx + IW'(1);
               end
            end
            S_OUT: begin
               if (y_ready) begin
                  state <= S_LOAD;
               end
            end
            default: begin
               state <= S_LOAD;
               idx   <= '0;
               n     <= '0;
               acc   <= BIAS;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/neuron_layer_sequencer.md
NEURON_LAYER_SEQUENCER -- requirements
Module: neuron_layer_sequencer

Interface
REQ-001 SHALL have parameter INPUT_COUNT, default 4: inputs per neuron (>=1).
REQ-002 SHALL have parameter NEURON_COUNT, default 4: neurons time-multiplexed on one MAC (>=1).
REQ-003 SHALL have parameter BIAS, 32 bit, default 0: accumulator start value for every neuron.
REQ-004 SHALL have parameter THRESHOLD, 32 bit, default 0: activation threshold.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port x_valid, input, 1: x_data is valid.
REQ-008 SHALL have port x_ready, output, 1: sequencer accepts an input word.
REQ-009 SHALL have port x_data, input, 32: input word; unsigned.
REQ-010 SHALL have port w_rd_en, output, 1: weight memory read strobe.
REQ-011 SHALL have port w_addr, output, $clog2(NEURON_COUNT*INPUT_COUNT) (min 1): weight address.
REQ-012 SHALL have port w_data, input, 32: weight word, valid the cycle after w_rd_en; unsigned.
REQ-013 SHALL have port y_valid, output, 1: result vector is valid.
REQ-014 SHALL have port y_ready, input, 1: consumer accepts the result vector.
REQ-015 SHALL have port y_data, output, NEURON_COUNT: bit n = activation of neuron n.

Function
REQ-016 SHALL implement a three-state FSM: LOAD, MAC, OUT.
REQ-017 In LOAD: x_ready=1; each edge with x_valid=1 stores x_data into buffer slot i (i = 0..INPUT_COUNT-1, in arrival order) and increments i.
REQ-018 The edge accepting slot INPUT_COUNT-1 SHALL move LOAD->MAC, clear i, and set neuron index n=0 and acc=BIAS.
REQ-019 MAC SHALL spend INPUT_COUNT+1 cycles per neuron: INPUT_COUNT issue cycles, then one finish cycle.
REQ-020 Issue cycle k: w_rd_en=1, w_addr=n*INPUT_COUNT+k; w_rd_en=0 in every finish cycle and outside MAC.
REQ-021 Each cycle after an issue cycle k (issue k+1 or finish), acc SHALL add x_buf[k]*w_data, product and sum truncated to 32 bits (mod 2^32).
REQ-022 Finish cycle: y_data[n] SHALL be set to ((acc + last product) > THRESHOLD), unsigned strict greater-than; acc reloads BIAS; n increments.
REQ-023 Finish of neuron NEURON_COUNT-1 SHALL move MAC->OUT; y_valid goes high exactly NEURON_COUNT*(INPUT_COUNT+1) edges after the last-input accept edge (20 for defaults).
REQ-024 In OUT: y_valid=1, x_ready=0, y_data stable; the edge with y_ready=1 moves OUT->LOAD with y_valid=0 and x_ready=1 the following cycle.
REQ-025 x_valid outside LOAD SHALL be ignored (no buffer write); y_ready outside OUT SHALL have no effect.
REQ-026 y_data bits SHALL keep the previous result until overwritten by the corresponding finish cycle.

Reset
REQ-027 rst_n=0 SHALL immediately force: state LOAD, i=0, n=0, acc=BIAS, x_ready=1 (asserted while in reset is permitted), w_rd_en=0, w_addr=0, y_valid=0, y_data=0; buffer contents unspecified.
REQ-028 Reset asserted mid-LOAD, mid-MAC or in OUT SHALL abort the operation; no partial result appears after release.
REQ-029 First input accept after release SHALL fill slot 0.

Verification
REQ-030 Defaults, THRESHOLD=15, weights of neuron n all = n+1, inputs 1,2,3,4 -> sums 10,20,30,40, y_data=4'b1110, y_valid 20 edges after 4th accept.
REQ-031 Same stimulus, THRESHOLD=20 -> y_data=4'b1100 (equality not activated).
REQ-032 x0=0x8000_0000, weight 2 for that input, all other x=0, BIAS=0, THRESHOLD=0 -> sum wraps to 0, y_data=4'b0000.
REQ-033 Address trace: w_addr 0..15 in order, w_rd_en pattern 4 high / 1 low repeated 4 times, x_ready=0 throughout MAC even with x_valid=1.
REQ-034 Hold y_ready=0 10 cycles in OUT -> y_valid and y_data stable, x_ready=0; raise y_ready -> next cycle x_ready=1, y_valid=0.
REQ-035 Assert rst_n=0 during neuron 2 of MAC -> all outputs at reset values immediately; after release, new 4-input load yields correct fresh result.
